// File: rtl/pipe_ctrl_pkg.sv
// Shared processor definitions for the pipeline controller: FSM encodings and
// stall-counter sizing.
package pipe_ctrl_pkg;

    localparam int REG_W       = 4;
    localparam int STALL_CNT_W = 16;

    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Read-after-write comparator between the ID-stage sources and the EX/MEM
// destinations, narrowed to load-use when forwarding is available.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_src1_en,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_wb_en,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             fwd_en,
    output logic             hazard_raw
);

    logic ex_match;
    logic mem_match;

    assign ex_match  = ex_wb_en && ((id_src1_en && (id_src1 == ex_dest)) ||
                                    (id_two_src && (id_src2 == ex_dest)));
    assign mem_match = mem_wb_en && ((id_src1_en && (id_src1 == mem_dest)) ||
                                     (id_two_src && (id_src2 == mem_dest)));

    // With forwarding only a load result still in EX cannot be bypassed.
    assign hazard_raw = fwd_en ? (ex_match && ex_mem_read) : (ex_match || mem_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: RAW bubbles, branch flushes and a
// memory-wait FSM that freezes the whole pipe while SRAM is busy.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_W-1:0]       id_src1,
    input  logic [REG_W-1:0]       id_src2,
    input  logic                   id_src1_en,
    input  logic                   id_two_src,
    input  logic [REG_W-1:0]       ex_dest,
    input  logic                   ex_wb_en,
    input  logic                   ex_mem_read,
    input  logic [REG_W-1:0]       mem_dest,
    input  logic                   mem_wb_en,
    input  logic                   mem_acc,
    input  logic                   fwd_en,
    input  logic                   ex_branch,
    input  logic                   sram_ready,
    output logic                   freeze_pc,
    output logic                   freeze_ifid,
    output logic                   flush_ifid,
    output logic                   flush_idex,
    output logic                   freeze_all,
    output logic                   sram_req,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    state_t cur_state;
    state_t nxt_state;
    logic   hazard_raw;
    logic   bubble;

    hazard_detect u_hazard (
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_src1_en  (id_src1_en),
        .id_two_src  (id_two_src),
        .ex_dest     (ex_dest),
        .ex_wb_en    (ex_wb_en),
        .ex_mem_read (ex_mem_read),
        .mem_dest    (mem_dest),
        .mem_wb_en   (mem_wb_en),
        .fwd_en      (fwd_en),
        .hazard_raw  (hazard_raw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= RUN;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // DONE always returns to RUN so the access leaving MEM is not re-issued.
    always_comb begin
        nxt_state = RUN;
        case (cur_state)
            RUN:     nxt_state = mem_acc ? WAIT : RUN;
            WAIT:    nxt_state = sram_ready ? DONE : WAIT;
            DONE:    nxt_state = RUN;
            default: nxt_state = RUN;
        endcase
    end

    always_comb begin
        freeze_all  = 1'b0;
        sram_req    = 1'b0;
        freeze_pc   = 1'b0;
        freeze_ifid = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        bubble      = 1'b0;
        case (cur_state)
            RUN: begin
                freeze_all = mem_acc;
                sram_req   = mem_acc;
            end
            WAIT: begin
                freeze_all = 1'b1;
                sram_req   = 1'b1;
            end
            default: ;
        endcase
        // Priority: memory freeze, then taken branch, then RAW bubble.
        if (freeze_all) begin
            freeze_pc   = 1'b1;
            freeze_ifid = 1'b1;
        end else if (ex_branch) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (hazard_raw) begin
            freeze_pc   = 1'b1;
            freeze_ifid = 1'b1;
            flush_idex  = 1'b1;
            bubble      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((freeze_all || bubble) && (stall_cnt != STALL_CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: an independent model pushes expected outputs
// into a scoreboard as stimulus is applied; they are popped and compared before the next edge.
module tb_pipe_ctrl;

    typedef struct packed {
        logic [3:0] id_src1;
        logic [3:0] id_src2;
        logic       id_src1_en;
        logic       id_two_src;
        logic [3:0] ex_dest;
        logic       ex_wb_en;
        logic       ex_mem_read;
        logic [3:0] mem_dest;
        logic       mem_wb_en;
        logic       mem_acc;
        logic       fwd_en;
        logic       ex_branch;
        logic       sram_ready;
    } stim_t;

    localparam stim_t IDLE = '0;

    logic        clk;
    logic        rst;
    stim_t       cur;
    logic        freeze_pc, freeze_ifid, flush_ifid, flush_idex, freeze_all, sram_req;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    logic [23:0] sb_q[$];
    logic [1:0]  m_state;
    logic [15:0] m_cnt;
    int          checks;
    int          errors;

    pipe_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_src1     (cur.id_src1),
        .id_src2     (cur.id_src2),
        .id_src1_en  (cur.id_src1_en),
        .id_two_src  (cur.id_two_src),
        .ex_dest     (cur.ex_dest),
        .ex_wb_en    (cur.ex_wb_en),
        .ex_mem_read (cur.ex_mem_read),
        .mem_dest    (cur.mem_dest),
        .mem_wb_en   (cur.mem_wb_en),
        .mem_acc     (cur.mem_acc),
        .fwd_en      (cur.fwd_en),
        .ex_branch   (cur.ex_branch),
        .sram_ready  (cur.sram_ready),
        .freeze_pc   (freeze_pc),
        .freeze_ifid (freeze_ifid),
        .flush_ifid  (flush_ifid),
        .flush_idex  (flush_idex),
        .freeze_all  (freeze_all),
        .sram_req    (sram_req),
        .state       (state),
        .stall_cnt   (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic modelHazard(stim_t s);
        logic ex_m;
        logic mem_m;
        ex_m  = s.ex_wb_en && ((s.id_src1_en && s.id_src1 == s.ex_dest) ||
                               (s.id_two_src && s.id_src2 == s.ex_dest));
        mem_m = s.mem_wb_en && ((s.id_src1_en && s.id_src1 == s.mem_dest) ||
                                (s.id_two_src && s.id_src2 == s.mem_dest));
        if (s.fwd_en) return ex_m && s.ex_mem_read;
        return ex_m || mem_m;
    endfunction

    function automatic logic modelFreeze(stim_t s, logic [1:0] st);
        return (st == 2'd0 && s.mem_acc) || st == 2'd1;
    endfunction

    function automatic logic [23:0] modelOut(stim_t s, logic [1:0] st, logic [15:0] cnt);
        logic fa, fpc, fif, flif, flid;
        fa = modelFreeze(s, st);
        fpc = 1'b0; fif = 1'b0; flif = 1'b0; flid = 1'b0;
        if (fa) begin
            fpc = 1'b1; fif = 1'b1;
        end else if (s.ex_branch) begin
            flif = 1'b1; flid = 1'b1;
        end else if (modelHazard(s)) begin
            fpc = 1'b1; fif = 1'b1; flid = 1'b1;
        end
        return {fpc, fif, flif, flid, fa, fa, st, cnt};
    endfunction

    // Accounts for the rising edge that occurred since the previous step.
    task automatic modelAdvance();
        logic stalled;
        if (rst) begin
            m_state = 2'd0;
            m_cnt   = 16'd0;
        end else begin
            stalled = modelFreeze(cur, m_state) ||
                      (!cur.ex_branch && modelHazard(cur));
            if (stalled && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            case (m_state)
                2'd0:    m_state = cur.mem_acc ? 2'd1 : 2'd0;
                2'd1:    m_state = cur.sram_ready ? 2'd2 : 2'd1;
                default: m_state = 2'd0;
            endcase
        end
    endtask

    task automatic checkValue(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        cur = s;
        sb_q.push_back(modelOut(s, m_state, m_cnt));
    endtask

    task automatic checkOutput(input string tag);
        logic [23:0] exp;
        #2;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s observed=scoreboard-empty expected=entry", tag);
        end else begin
            exp = sb_q.pop_front();
            checkValue(tag, {freeze_pc, freeze_ifid, flush_ifid, flush_idex,
                             freeze_all, sram_req, state, stall_cnt}, exp);
        end
    endtask

    task automatic step(input stim_t s, input string tag);
        @(negedge clk);
        modelAdvance();
        applyStimulus(s);
        checkOutput(tag);
    endtask

    stim_t s, lu, haz;

    initial begin
        checks  = 0;
        errors  = 0;
        m_state = 2'd0;
        m_cnt   = 16'd0;
        cur     = IDLE;
        rst     = 1'b0;
        #1 rst  = 1'b1;
        #2;
        checkValue("reset_async", {6'b0, state, stall_cnt}, 24'h0);
        checkValue("reset_outs", {18'b0, freeze_pc, freeze_ifid, flush_ifid, flush_idex,
                                  freeze_all, sram_req}, 24'h0);
        #4 rst = 1'b0;

        step(IDLE, "idle");
        s = IDLE; s.sram_ready = 1'b1;
        step(s, "ready_in_run");

        lu = IDLE;
        lu.fwd_en = 1'b1; lu.ex_mem_read = 1'b1; lu.ex_wb_en = 1'b1;
        lu.ex_dest = 4'd3; lu.id_src1 = 4'd3; lu.id_src1_en = 1'b1;
        step(lu, "load_use");
        step(IDLE, "load_use_clear");
        checkValue("load_use_cnt", {8'b0, stall_cnt}, 24'd1);

        s = IDLE;
        s.mem_wb_en = 1'b1; s.mem_dest = 4'd5; s.id_two_src = 1'b1; s.id_src2 = 4'd5;
        step(s, "mem_nofwd");
        s.fwd_en = 1'b1;
        step(s, "mem_fwd");
        s.fwd_en = 1'b0; s.id_two_src = 1'b0;
        step(s, "src2_disabled");

        s = lu; s.ex_branch = 1'b1;
        step(s, "branch_hazard");
        step(IDLE, "post_branch");
        checkValue("branch_cnt", {8'b0, stall_cnt}, 24'd2);

        s = IDLE; s.mem_acc = 1'b1;
        step(s, "mem_run");
        step(s, "mem_wait1");
        step(s, "mem_wait2");
        step(s, "mem_wait3");
        s.sram_ready = 1'b1;
        step(s, "mem_wait_ready");
        step(s, "mem_done");
        s = IDLE;
        step(s, "mem_back_run");
        checkValue("mem_wait_cnt", {8'b0, stall_cnt}, 24'd7);

        s = IDLE; s.mem_acc = 1'b1; s.ex_branch = 1'b1;
        step(s, "brfrz_run");
        s.mem_acc = 1'b0;
        step(s, "brfrz_wait");
        s.sram_ready = 1'b1;
        step(s, "brfrz_ready");
        s.sram_ready = 1'b0;
        step(s, "brfrz_done_flush");
        step(IDLE, "brfrz_after");

        s = IDLE; s.mem_acc = 1'b1;
        step(s, "rstwait_run");
        s.mem_acc = 1'b0;
        step(s, "rstwait_wait");
        #1 rst = 1'b1;
        m_state = 2'd0;
        m_cnt   = 16'd0;
        #1;
        checkValue("rst_mid_wait", {4'b0, freeze_all, sram_req, state, stall_cnt}, 24'h0);
        s.mem_acc = 1'b1;
        step(s, "rst_held_memacc");
        step(IDLE, "rst_held_idle");
        rst = 1'b0;

        haz = IDLE;
        haz.ex_wb_en = 1'b1; haz.ex_dest = 4'd7; haz.id_src1 = 4'd7; haz.id_src1_en = 1'b1;
        step(haz, "sat_start");
        repeat (65533) begin
            @(negedge clk);
            modelAdvance();
        end
        step(haz, "sat_fffe");
        checkValue("preload_fffe", {8'b0, stall_cnt}, 24'h00FFFE);
        step(haz, "sat_1");
        step(haz, "sat_2");
        step(haz, "sat_3");
        checkValue("saturated", {8'b0, stall_cnt}, 24'h00FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
